// File: rtl/enemy_shot_pkg.sv
// Shared constants and types for the enemy projectile engine.
`timescale 1ns/1ps
package enemy_shot_pkg;

    localparam int FIXED_POINT_MULTIPLIER = 64;
    localparam int FP_SHIFT               = 6;
    localparam int SCREEN_HEIGHT          = 480;

    typedef enum logic {
        IDLE   = 1'b0,
        FLYING = 1'b1
    } slot_state_t;

    // Smallest counter width that can hold max_value (never below one bit).
    function automatic int counter_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/enemy_shot_if.sv
// Bus between the enemy shot pool and its environment (enemy matrix, drawing, collision).
`timescale 1ns/1ps
interface enemy_shot_if #(
    parameter int NUM_SHOTS = 4
);
    logic                              startOfFrame;
    logic                              pause;
    logic                              fireRequest;
    logic signed [10:0]                enemy_topLeftX;
    logic signed [10:0]                enemy_topLeftY;
    logic        [NUM_SHOTS-1:0]       shotPlayerCollision;
    logic        [NUM_SHOTS-1:0]       shotBoxCollision;
    logic        [NUM_SHOTS-1:0]       active;
    logic signed [NUM_SHOTS-1:0][10:0] topLeftX;
    logic signed [NUM_SHOTS-1:0][10:0] topLeftY;
    logic                              fireAccepted;
    logic                              playerHit;

    modport master (
        output startOfFrame, pause, fireRequest, enemy_topLeftX, enemy_topLeftY,
               shotPlayerCollision, shotBoxCollision,
        input  active, topLeftX, topLeftY, fireAccepted, playerHit
    );

    modport slave (
        input  startOfFrame, pause, fireRequest, enemy_topLeftX, enemy_topLeftY,
               shotPlayerCollision, shotBoxCollision,
        output active, topLeftX, topLeftY, fireAccepted, playerHit
    );

endinterface

// File: rtl/enemy_shot_slot.sv
// One enemy shot: fixed-point position, downward motion, floor retirement and hit flag.
`timescale 1ns/1ps
module enemy_shot_slot
    import enemy_shot_pkg::*;
#(
    parameter int SPEED   = 96,
    parameter int FLOOR_Y = SCREEN_HEIGHT - 1
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               frameStrobe,
    input  logic               load,
    input  logic signed [31:0] loadX,
    input  logic signed [31:0] loadY,
    input  logic               playerCollision,
    input  logic               boxCollision,
    output logic               active,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic               hit
);

    localparam logic signed [31:0] FLOOR_FP = 32'(FLOOR_Y * FIXED_POINT_MULTIPLIER);
    localparam logic signed [31:0] STEP_FP  = 32'(SPEED);

    slot_state_t        state;
    logic signed [31:0] x_fp;
    logic signed [31:0] y_fp;
    logic signed [31:0] y_next;

    assign y_next = y_fp + STEP_FP;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
            x_fp  <= '0;
            y_fp  <= '0;
            hit   <= 1'b0;
        end else begin
            hit <= 1'b0;
            if (state == FLYING) begin
                // A collision on the same edge as a frame step wins over the move.
                if (playerCollision || boxCollision) begin
                    state <= IDLE;
                    hit   <= playerCollision;
                end else if (frameStrobe) begin
                    if (y_next > FLOOR_FP) begin
                        state <= IDLE;
                    end else begin
                        y_fp <= y_next;
                    end
                end
            end else if (load) begin
                state <= FLYING;
                x_fp  <= loadX;
                y_fp  <= loadY;
            end
        end
    end

    assign active   = (state == FLYING);
    assign topLeftX = active ? 11'(x_fp >>> FP_SHIFT) : '0;
    assign topLeftY = active ? 11'(y_fp >>> FP_SHIFT) : '0;

endmodule

// File: rtl/enemy_shot_pool.sv
// Enemy projectile engine: request latch, fire cooldown, slot allocation and hit reporting.
`timescale 1ns/1ps
module enemy_shot_pool
    import enemy_shot_pkg::*;
#(
    parameter int NUM_SHOTS       = 4,
    parameter int SPEED           = 96,
    parameter int COOLDOWN_FRAMES = 20,
    parameter int SPAWN_OFFSET_Y  = 32,
    parameter int FLOOR_Y         = SCREEN_HEIGHT - 1
) (
    input  logic        clk,
    input  logic        resetN,
    enemy_shot_if.slave bus
);

    localparam int CD_W = counter_width(COOLDOWN_FRAMES);

    logic                  pending;
    logic signed [10:0]    req_x;
    logic signed [10:0]    req_y;
    logic [CD_W-1:0]       cooldown;
    logic                  fire_service;
    logic                  frame_step;
    logic                  found;
    logic [NUM_SHOTS-1:0]  load_vec;
    logic [NUM_SHOTS-1:0]  slot_active;
    logic [NUM_SHOTS-1:0]  slot_hit;
    logic [NUM_SHOTS-1:0][10:0] slot_x;
    logic [NUM_SHOTS-1:0][10:0] slot_y;
    logic signed [31:0]    spawn_x_fp;
    logic signed [31:0]    spawn_y_fp;
    logic                  fire_accepted;

    assign frame_step   = bus.startOfFrame && !bus.pause;
    assign fire_service = pending && (cooldown == '0) && !(&slot_active) && !bus.pause;

    assign spawn_x_fp = 32'(req_x) <<< FP_SHIFT;
    assign spawn_y_fp = (32'(req_y) + SPAWN_OFFSET_Y) <<< FP_SHIFT;

    // Lowest-index idle slot, judged on pre-edge state so a retiring slot is not reused yet.
    // NOTE: every variable driven here gets a default first, otherwise synthesis infers latches.
    always_comb begin
        load_vec = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            if (!slot_active[i] && !found) begin
                load_vec[i] = fire_service;
                found       = 1'b1;
            end
        end
    end

    // Newest request always wins; one arriving on a service edge becomes the next pending shot.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pending <= 1'b0;
            req_x   <= '0;
            req_y   <= '0;
        end else if (bus.fireRequest) begin
            pending <= 1'b1;
            req_x   <= bus.enemy_topLeftX;
            req_y   <= bus.enemy_topLeftY;
        end else if (fire_service) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cooldown      <= '0;
            fire_accepted <= 1'b0;
        end else begin
            fire_accepted <= fire_service;
            if (fire_service) begin
                cooldown <= CD_W'(COOLDOWN_FRAMES);
            end else if (frame_step && (cooldown != '0)) begin
                cooldown <= cooldown - 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_SHOTS; i++) begin : g_slot
        enemy_shot_slot #(
            .SPEED   (SPEED),
            .FLOOR_Y (FLOOR_Y)
        ) u_slot (
            .clk             (clk),
            .resetN          (resetN),
            .frameStrobe     (frame_step),
            .load            (load_vec[i]),
            .loadX           (spawn_x_fp),
            .loadY           (spawn_y_fp),
            .playerCollision (bus.shotPlayerCollision[i]),
            .boxCollision    (bus.shotBoxCollision[i]),
            .active          (slot_active[i]),
            .topLeftX        (slot_x[i]),
            .topLeftY        (slot_y[i]),
            .hit             (slot_hit[i])
        );
    end

    assign bus.active       = slot_active;
    assign bus.topLeftX     = slot_x;
    assign bus.topLeftY     = slot_y;
    assign bus.fireAccepted = fire_accepted;
    assign bus.playerHit    = |slot_hit;

endmodule

// File: tb/tb_enemy_shot_pool.sv
// Directed scoreboard bench for enemy_shot_pool: one instance with cooldown, one without.
`timescale 1ns/1ps
module tb_enemy_shot_pool;

    logic clk = 1'b0;
    logic resetN;

    always #5 clk = ~clk;

    enemy_shot_if #(.NUM_SHOTS(4)) ifa ();
    enemy_shot_if #(.NUM_SHOTS(4)) ifb ();

    enemy_shot_pool #(.NUM_SHOTS(4), .COOLDOWN_FRAMES(20)) dut_a (
        .clk    (clk),
        .resetN (resetN),
        .bus    (ifa)
    );

    enemy_shot_pool #(.NUM_SHOTS(4), .COOLDOWN_FRAMES(0)) dut_b (
        .clk    (clk),
        .resetN (resetN),
        .bus    (ifb)
    );

    typedef struct {
        int slot;
        int x;
        int y;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pops the oldest expected spawn and compares it with the slot it should occupy.
    task automatic check_accept(input string tag, input logic acc, input logic [3:0] act,
                                input logic [3:0][10:0] tx, input logic [3:0][10:0] ty);
        exp_t e;
        check({tag, "_acc"}, 64'(acc), 64'd1);
        n_checks++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_active"}, 64'(act[e.slot]), 64'd1);
        check({tag, "_x"}, 64'(tx[e.slot]), 64'(e.x));
        check({tag, "_y"}, 64'(ty[e.slot]), 64'(e.y));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0;
        ifa.startOfFrame = 0; ifa.pause = 0; ifa.fireRequest = 0;
        ifa.enemy_topLeftX = '0; ifa.enemy_topLeftY = '0;
        ifa.shotPlayerCollision = '0; ifa.shotBoxCollision = '0;
        ifb.startOfFrame = 0; ifb.pause = 0; ifb.fireRequest = 0;
        ifb.enemy_topLeftX = '0; ifb.enemy_topLeftY = '0;
        ifb.shotPlayerCollision = '0; ifb.shotBoxCollision = '0;
        repeat (2) tick();
        check("rst_active", 64'(ifa.active), 64'd0);
        check("rst_acc", 64'(ifa.fireAccepted), 64'd0);
        check("rst_hit", 64'(ifa.playerHit), 64'd0);
        check("rst_x", 64'(ifa.topLeftX), 64'd0);
        check("rst_y", 64'(ifa.topLeftY), 64'd0);
        resetN = 1'b1;
        tick();

        // First shot: request at edge T, visible after edge T+1.
        ifa.enemy_topLeftX = 11'd100; ifa.enemy_topLeftY = 11'd50; ifa.fireRequest = 1;
        exp_q.push_back('{slot: 0, x: 100, y: 82});
        tick();
        ifa.fireRequest = 0;
        check("latency_active", 64'(ifa.active), 64'd0);
        tick();
        check_accept("fire0", ifa.fireAccepted, ifa.active, ifa.topLeftX, ifa.topLeftY);
        check("fire0_onehot", 64'(ifa.active), 64'b0001);
        tick();
        check("acc_pulse", 64'(ifa.fireAccepted), 64'd0);

        // Second request one frame after the first accept; cooldown gates it for 20 frames.
        for (int k = 1; k <= 20; k++) begin
            ifa.startOfFrame = 1;
            tick();
            ifa.startOfFrame = 0;
            check("cd_hold_sof", 64'(ifa.fireAccepted), 64'd0);
            if (k == 10) check("move10_y", 64'(ifa.topLeftY[0]), 64'd97);
            if (k == 1) begin
                ifa.enemy_topLeftX = 11'd200; ifa.enemy_topLeftY = 11'd10; ifa.fireRequest = 1;
                exp_q.push_back('{slot: 1, x: 200, y: 42});
            end
            tick();
            ifa.fireRequest = 0;
            if (k < 20) check("cd_hold", 64'(ifa.fireAccepted), 64'd0);
            else check_accept("fire_cd", ifa.fireAccepted, ifa.active, ifa.topLeftX, ifa.topLeftY);
        end
        check("move20_y", 64'(ifa.topLeftY[0]), 64'd112);

        // Player collision on slot1 held for three cycles.
        ifa.shotPlayerCollision = 4'b0010;
        tick();
        check("hit_pulse", 64'(ifa.playerHit), 64'd1);
        check("hit_active", 64'(ifa.active), 64'b0001);
        tick();
        check("hit_once1", 64'(ifa.playerHit), 64'd0);
        tick();
        check("hit_once2", 64'(ifa.playerHit), 64'd0);
        ifa.shotPlayerCollision = '0;
        check("hit_keep_x", 64'(ifa.topLeftX[0]), 64'd100);
        check("hit_keep_y", 64'(ifa.topLeftY[0]), 64'd112);

        // Pause for 5 frames with a pending request, then resume.
        ifa.enemy_topLeftX = 11'd300; ifa.enemy_topLeftY = 11'd100; ifa.fireRequest = 1;
        exp_q.push_back('{slot: 1, x: 300, y: 132});
        tick();
        ifa.fireRequest = 0;
        ifa.pause = 1;
        for (int k = 0; k < 5; k++) begin
            ifa.startOfFrame = 1;
            tick();
            ifa.startOfFrame = 0;
            tick();
            check("pause_y", 64'(ifa.topLeftY[0]), 64'd112);
            check("pause_acc", 64'(ifa.fireAccepted), 64'd0);
        end
        ifa.pause = 0;
        for (int k = 1; k <= 20; k++) begin
            ifa.startOfFrame = 1;
            tick();
            ifa.startOfFrame = 0;
            check("resume_hold_sof", 64'(ifa.fireAccepted), 64'd0);
            if (k == 1) check("resume_y", 64'(ifa.topLeftY[0]), 64'd113);
            tick();
            if (k < 20) check("resume_hold", 64'(ifa.fireAccepted), 64'd0);
            else check_accept("fire_resume", ifa.fireAccepted, ifa.active, ifa.topLeftX, ifa.topLeftY);
        end

        // No cooldown: five back-to-back requests fill four slots, the fifth waits.
        for (int i = 0; i < 5; i++) begin
            ifb.enemy_topLeftX = 11'(10 + 10 * i);
            ifb.enemy_topLeftY = 11'(20 + i);
            ifb.fireRequest = 1;
            exp_q.push_back('{slot: (i < 4) ? i : 2, x: 10 + 10 * i, y: 52 + i});
            tick();
            if (i > 0) check_accept($sformatf("fill%0d", i - 1), ifb.fireAccepted,
                                    ifb.active, ifb.topLeftX, ifb.topLeftY);
        end
        ifb.fireRequest = 0;
        tick();
        check("full_acc", 64'(ifb.fireAccepted), 64'd0);
        check("full_active", 64'(ifb.active), 64'b1111);
        ifb.shotBoxCollision = 4'b0100;
        tick();
        ifb.shotBoxCollision = '0;
        check("box_active", 64'(ifb.active), 64'b1011);
        check("box_acc", 64'(ifb.fireAccepted), 64'd0);
        check("box_nohit", 64'(ifb.playerHit), 64'd0);
        tick();
        check_accept("refill", ifb.fireAccepted, ifb.active, ifb.topLeftX, ifb.topLeftY);
        check("refill_active", 64'(ifb.active), 64'b1111);

        // Floor retirement: spawn at pixel row 470 and step 1.5 px per frame.
        ifb.shotBoxCollision = 4'b1111;
        tick();
        ifb.shotBoxCollision = '0;
        check("clear_active", 64'(ifb.active), 64'd0);
        ifb.enemy_topLeftX = 11'd5; ifb.enemy_topLeftY = 11'd438; ifb.fireRequest = 1;
        exp_q.push_back('{slot: 0, x: 5, y: 470});
        tick();
        ifb.fireRequest = 0;
        tick();
        check_accept("floor_spawn", ifb.fireAccepted, ifb.active, ifb.topLeftX, ifb.topLeftY);
        for (int k = 1; k <= 7; k++) begin
            ifb.startOfFrame = 1;
            tick();
            ifb.startOfFrame = 0;
            check("floor_nohit", 64'(ifb.playerHit), 64'd0);
            if (k == 6) check("floor_y479", 64'(ifb.topLeftY[0]), 64'd479);
            if (k < 7) check("floor_alive", 64'(ifb.active[0]), 64'd1);
            else begin
                check("floor_retired", 64'(ifb.active[0]), 64'd0);
                check("floor_zero_y", 64'(ifb.topLeftY[0]), 64'd0);
            end
            tick();
            check("floor_nohit2", 64'(ifb.playerHit), 64'd0);
        end

        // Reset mid-flight clears every in-flight shot immediately.
        ifb.enemy_topLeftX = 11'd1; ifb.enemy_topLeftY = 11'd1; ifb.fireRequest = 1;
        exp_q.push_back('{slot: 0, x: 1, y: 33});
        tick();
        ifb.fireRequest = 0;
        tick();
        check_accept("pre_reset", ifb.fireAccepted, ifb.active, ifb.topLeftX, ifb.topLeftY);
        resetN = 1'b0;
        #2;
        check("midrst_active_a", 64'(ifa.active), 64'd0);
        check("midrst_active_b", 64'(ifb.active), 64'd0);
        check("midrst_y_b", 64'(ifb.topLeftY), 64'd0);
        tick();
        resetN = 1'b1;
        tick();
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
